// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the core decoder and the M-extension sequencer.
// The core drives request and flush fields, and the sequencer returns stall, status and result.
interface muldiv_seq_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic [2:0]      funct3;
   logic [XLEN-1:0] rs1;
   logic [XLEN-1:0] rs2;
   logic            flush;
   logic            stall;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (
      output start, funct3, rs1, rs2, flush,
      input  stall, busy, done, result
   );

   modport slave (
      input  start, funct3, rs1, rs2, flush,
      output stall, busy, done, result
   );
endinterface

// File: rtl/muldiv_seq.sv
// RV32 M-extension sequencer with 32-step shift-add multiply and restoring divide; 33 cycles per op, or 1 for special cases.
// Stalls the core combinationally from start until the DONE cycle; start is ignored while busy, and flush aborts.
module muldiv_seq #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 5
) (
   input logic         clk,
   input logic         rst_n,
   muldiv_seq_if.slave bus
);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]      op;
   logic [XLEN-1:0] opa, opb, hi, lo;
   logic            neg_q, neg_r;
   logic            busy, done;
   logic [XLEN-1:0] result;

   // operand conditioning, evaluated on the request inputs
   logic            sgn_a, sgn_b, div_zero, div_ovf;
   logic [XLEN-1:0] mag_a, mag_b, spec_res;

   always_comb begin
      sgn_a    = ((bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                  (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110)) && bus.rs1[XLEN-1];
      sgn_b    = ((bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                  (bus.funct3 == 3'b110)) && bus.rs2[XLEN-1];
      mag_a    = sgn_a ? -bus.rs1 : bus.rs1;
      mag_b    = sgn_b ? -bus.rs2 : bus.rs2;
      div_zero = bus.funct3[2] && (bus.rs2 == '0);
      div_ovf  = bus.funct3[2] && !bus.funct3[0] &&
                 (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2 == '1);
      // overflowed DIV returns the dividend itself, which is 0x80000000
      if (div_zero)
         spec_res = bus.funct3[1] ? bus.rs1 : '1;
      else
         spec_res = bus.funct3[1] ? '0 : bus.rs1;
   end

   // one iteration step; hi/lo hold product halves or remainder/quotient
   logic [XLEN:0]     msum, trial;
   logic [XLEN-1:0]   hi_nx, lo_nx, quo, rem;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   calc_res;

   always_comb begin
      msum  = {1'b0, hi} + (lo[0] ? {1'b0, opa} : '0);
      trial = {hi, lo[XLEN-1]} - {1'b0, opb};
      hi_nx = hi;
      lo_nx = lo;
      if (!op[2]) begin
         {hi_nx, lo_nx} = {msum, lo[XLEN-1:1]};
      end else if (!trial[XLEN]) begin
         hi_nx = trial[XLEN-1:0];
         lo_nx = {lo[XLEN-2:0], 1'b1};
      end else begin
         hi_nx = {hi[XLEN-2:0], lo[XLEN-1]};
         lo_nx = {lo[XLEN-2:0], 1'b0};
      end
      prod = neg_q ? -{hi_nx, lo_nx} : {hi_nx, lo_nx};
      quo  = neg_q ? -lo_nx : lo_nx;
      rem  = neg_r ? -hi_nx : hi_nx;
      if (!op[2])
         calc_res = (op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      else
         calc_res = op[1] ? rem : quo;
   end

   assign bus.stall  = ((state == IDLE) && bus.start && !bus.flush) || (state == CALC);
   assign bus.busy   = busy;
   assign bus.done   = done;
   assign bus.result = result;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         op     <= '0;
         opa    <= '0;
         opb    <= '0;
         hi     <= '0;
         lo     <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
      end else if (bus.flush) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (bus.start) begin
                  op    <= bus.funct3;
                  opa   <= mag_a;
                  opb   <= mag_b;
                  neg_q <= sgn_a ^ sgn_b;
                  neg_r <= sgn_a;
                  cnt   <= '0;
                  hi    <= '0;
                  lo    <= bus.funct3[2] ? mag_a : mag_b;
                  busy  <= 1'b1;
                  if (div_zero || div_ovf) begin
                     result <= spec_res;
                     done   <= 1'b1;
                     state  <= DONE;
                  end else begin
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               hi <= hi_nx;
               lo <= lo_nx;
               if (cnt == CNT_W'(XLEN-1)) begin
                  result <= calc_res;
                  done   <= 1'b1;
                  state  <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: stimulus pushes hand-computed results into a scoreboard,
// and a negedge monitor pops and checks them on every done pulse.
module tb_muldiv_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   vecs = 0;
   int   errs = 0;

   typedef struct {
      logic [31:0] res;
      int          lat;
      int          t0;
      string       name;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   logic [31:0] last_exp = '0;

   muldiv_seq_if #(.XLEN(32)) bus ();

   muldiv_seq #(.XLEN(32), .CNT_W(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (rst_n && bus.done) begin
         if (sb.size() == 0) begin
            vecs++;
            errs++;
            $display("FAIL unexpected_done: got result %h with nothing expected", bus.result);
         end else begin
            e = sb.pop_front();
            chk({e.name, "_result"}, bus.result, e.res);
            chk({e.name, "_latency"}, 32'(cyc - e.t0), 32'(e.lat));
         end
      end
   end

   task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat,
                         input bit poke);
      int stalls;
      bit got;
      @(negedge clk);
      bus.funct3 = f3;
      bus.rs1    = a;
      bus.rs2    = b;
      bus.start  = 1'b1;
      sb.push_back('{exp, lat, cyc, nm});
      last_exp = exp;
      #1;
      stalls = 0;
      got    = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (bus.stall) stalls++;
         @(negedge clk);
         if (poke && i == 5) begin
            bus.start  = 1'b1;
            bus.funct3 = 3'b000;
            bus.rs1    = 32'h55;
            bus.rs2    = 32'h55;
         end else begin
            bus.start = 1'b0;
         end
         #1;
         if (bus.done) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         vecs++;
         errs++;
         $display("FAIL %s_timeout: got no done within 40 cycles, expected done", nm);
      end
      chk({nm, "_stall_cycles"}, 32'(stalls), 32'(lat));
      chk({nm, "_stall_in_done"}, {31'b0, bus.stall}, 32'h0);
   endtask

   initial begin
      bus.start  = 1'b0;
      bus.funct3 = 3'b000;
      bus.rs1    = '0;
      bus.rs2    = '0;
      bus.flush  = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_busy", {31'b0, bus.busy}, 32'h0);
      chk("reset_done", {31'b0, bus.done}, 32'h0);
      chk("reset_result", bus.result, 32'h0);
      chk("reset_stall", {31'b0, bus.stall}, 32'h0);
      rst_n = 1'b1;

      run_op("mul_7x6",      3'b000, 32'd7,        32'd6,        32'd42,       33, 1'b0);
      run_op("mulh_m1x2",    3'b001, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 33, 1'b0);
      run_op("mulhu_m1x2",   3'b011, 32'hFFFFFFFF, 32'h2,        32'h1,        33, 1'b1);
      run_op("mulhsu_m1x2",  3'b010, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 33, 1'b0);
      run_op("mul_max_sq",   3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        33, 1'b0);
      run_op("mulhu_max_sq", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 1'b0);
      run_op("div_m7_2",     3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 1'b0);
      run_op("rem_m7_2",     3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 1'b0);
      run_op("div_7_m2",     3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33, 1'b0);
      run_op("rem_7_m2",     3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        33, 1'b0);
      run_op("divu_100_7",   3'b101, 32'd100,      32'd7,        32'd14,       33, 1'b0);
      run_op("remu_100_7",   3'b111, 32'd100,      32'd7,        32'd2,        33, 1'b0);
      run_op("divu_by0",     3'b101, 32'h1234,     32'h0,        32'hFFFFFFFF, 1,  1'b0);
      run_op("remu_by0",     3'b111, 32'h1234,     32'h0,        32'h1234,     1,  1'b0);
      run_op("div_by0",      3'b100, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFFF, 1,  1'b0);
      run_op("div_ovf",      3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  1'b0);
      run_op("rem_ovf",      3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1,  1'b0);

      // flush at CALC cycle 10 with an ignored start pulse in between
      @(negedge clk);
      bus.funct3 = 3'b100;
      bus.rs1    = 32'hFFFFFFF9;
      bus.rs2    = 32'd2;
      bus.start  = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         bus.start = (i == 5);
      end
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      #1;
      chk("flush_busy", {31'b0, bus.busy}, 32'h0);
      chk("flush_stall", {31'b0, bus.stall}, 32'h0);
      chk("flush_result_kept", bus.result, last_exp);
      run_op("divu_after_flush", 3'b101, 32'd100, 32'd7, 32'd14, 33, 1'b0);

      // synchronous reset at CALC cycle 20
      @(negedge clk);
      bus.funct3 = 3'b100;
      bus.rs1    = 32'd1000;
      bus.rs2    = 32'd3;
      bus.start  = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("midreset_busy", {31'b0, bus.busy}, 32'h0);
      chk("midreset_done", {31'b0, bus.done}, 32'h0);
      chk("midreset_result", bus.result, 32'h0);
      run_op("mul_3x5", 3'b000, 32'd3, 32'd5, 32'd15, 33, 1'b0);

      repeat (5) @(negedge clk);
      chk("scoreboard_drained", 32'(sb.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
